// File: rtl/proc_mem_responder_if.sv
// Processor memory bus: address, write data, write enable out; read data back.
// The master modport is the processor side; the slave modport is the memory responder.
interface proc_mem_responder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] o_memAddr;
    logic [DATA_W-1:0] o_memData;
    logic              o_memWrEnable;
    logic [DATA_W-1:0] i_memData;

    modport master (
        output o_memAddr,
        output o_memData,
        output o_memWrEnable,
        input  i_memData
    );

    modport slave (
        input  o_memAddr,
        input  o_memData,
        input  o_memWrEnable,
        output i_memData
    );
endinterface

// File: rtl/proc_mem_responder.sv
// Memory-side responder for the processor bus: 1-cycle read latency, no backpressure (one bus cycle per clock).
// Build option MEM_WRITE_FIRST_EN: write cycles return the new data instead of the old array contents.
module proc_mem_responder #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    proc_mem_responder_if.slave   bus,
    input  logic                  i_loadEn,
    input  logic [DEPTH_LOG2-1:0] i_loadAddr,
    input  logic [DATA_W-1:0]     i_loadData,
    output logic                  o_errAddr,
    output logic [15:0]           o_rdCount,
    output logic [15:0]           o_wrCount
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DATA_W-1:0]     r_rd_dat;
    logic                  r_err;
    logic [15:0]           r_rd_cnt;
    logic [15:0]           r_wr_cnt;

    logic                  w_in_range;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_bus_wr;
    logic [DATA_W-1:0]     w_rd_nxt;

    assign w_in_range = ((bus.o_memAddr >> DEPTH_LOG2) == '0);
    assign w_idx      = bus.o_memAddr[DEPTH_LOG2-1:0];
    assign w_bus_wr   = i_rst && w_in_range && bus.o_memWrEnable;

    // Array has no reset; load port is live even while the bus is held in reset.
    // The load write is issued last so it wins a same-address collision.
    always_ff @(posedge i_clk) begin
        if (w_bus_wr) begin
            r_mem[w_idx] <= bus.o_memData;
        end
        if (i_loadEn) begin
            r_mem[i_loadAddr] <= i_loadData;
        end
    end

    always_comb begin
        w_rd_nxt = '0;
        if (w_in_range) begin
`ifdef MEM_WRITE_FIRST_EN
            w_rd_nxt = bus.o_memWrEnable ? bus.o_memData : r_mem[w_idx];
`else
            w_rd_nxt = r_mem[w_idx];
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rd_dat <= '0;
            r_err    <= 1'b0;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            r_rd_dat <= w_rd_nxt;
            if (!w_in_range) begin
                r_err <= 1'b1;
            end else if (bus.o_memWrEnable) begin
                if (r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
            end else begin
                if (r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
            end
        end
    end

    assign bus.i_memData = r_rd_dat;
    assign o_errAddr     = r_err;
    assign o_rdCount     = r_rd_cnt;
    assign o_wrCount     = r_wr_cnt;
endmodule

// File: doc/proc_mem_responder.md
# proc_mem_responder

Synthesizable memory-side responder for the basic processor's memory bus. It accepts the processor's address, write data and write enable, stores writes into an internal word array, and returns read data on the processor's data input with one cycle of latency. A side load port preloads program/data images while the processor is held in reset. Sticky error and saturating access counters support debug and coverage. It sits opposite the processor core on the same four-signal bus that the verification agent drives and monitors.

## Interface
- `DATA_W`, default 16: memory word width in bits.
- `ADDR_W`, default 16: bus address width in bits.
- `DEPTH_LOG2`, default 8: log2 of the number of implemented words (256); must satisfy DEPTH_LOG2 <= ADDR_W.

Ports:
- `i_clk`  input  1: single clock; all logic is on the rising edge.
- `i_rst`  input  1: asynchronous, active-low reset.
- `o_memAddr`  input  ADDR_W: word address from the processor.
- `o_memData`  input  DATA_W: write data from the processor.
- `o_memWrEnable`  input  1: 1 = write cycle, 0 = read cycle.
- `i_memData`  output  DATA_W: read data returned to the processor.
- `i_loadEn`  input  1: load-port write strobe.
- `i_loadAddr`  input  DEPTH_LOG2: load-port word address.
- `i_loadData`  input  DATA_W: load-port write data.
- `o_errAddr`  output  1: sticky flag, set by any bus access with address >= 2^DEPTH_LOG2.
- `o_rdCount`  output  16: saturating count of in-range bus read cycles.
- `o_wrCount`  output  16: saturating count of in-range bus write cycles.

## Operation
- Every clock with `i_rst` high is one bus cycle. It is a write if `o_memWrEnable` = 1 and a read otherwise. There is no idle state.
- In-range write: mem[o_memAddr] <= o_memData; `o_wrCount` increments.
- In-range read: the read register captures mem[o_memAddr]; `o_rdCount` increments.
- Out-of-range access (upper address bits nonzero):
  - the array is unchanged;
  - the read register captures 0;
  - `o_errAddr` is set;
  - no counter changes.
- `o_errAddr` clears only on reset.
- Counters saturate at 16'hFFFF and never wrap.
- Load port: when `i_loadEn` = 1, mem[i_loadAddr] <= i_loadData.
  - The load port operates regardless of `i_rst`.
  - If a load and an in-range bus write target the same cycle, the load wins. The bus write is discarded but still counted.
  - Loads never change counters or `o_errAddr`.
- A write cycle also updates the read register, per the Configuration section, so `i_memData` always reflects the previous cycle's address.
- The array has no reset. Its contents survive `i_rst` assertion.

## Timing
- Read latency is 1 cycle: the address presented before edge N appears on `i_memData` after edge N and holds until edge N+1.
- Back-to-back reads to different addresses stream at one word per cycle.
- Write data is visible to a read presented in the next cycle, through the array.
- Reset (`i_rst` low, asynchronous) clears immediately: `i_memData` = 0, `o_errAddr` = 0, `o_rdCount` = 0, `o_wrCount` = 0.
- On release, the first bus cycle is sampled at the first rising edge with `i_rst` high.
- Reset mid-operation: an in-flight read result is lost (output forced to 0). A write sampled on an edge before the reset assertion is retained in the array.
- The load port writes on the rising edge with 0-cycle setup relative to the bus. A bus read of the loaded address in the next cycle returns the loaded data.

## Configuration
- `MEM_WRITE_FIRST_EN`:
  - Defined: on an in-range write cycle, `i_memData` next cycle = `o_memData` (new data, write-first).
  - Undefined: `i_memData` next cycle = the array contents before the write (read-first).
  - Out-of-range write cycles return 0 in both modes.

## Test plan
- Reset/defaults: hold `i_rst` = 0, preload addr 8'h10 = 16'hBEEF via the load port, release reset, read 16'h0010 -> `i_memData` = 16'hBEEF one cycle later. During reset all four outputs read 0.
- Write then read: write 16'h1234 to 16'h0020, then read 16'h0020 -> 16'h1234; `o_wrCount` = 1, `o_rdCount` = 1.
- Write-first vs read-first: mem[5] = 16'h0001, write 16'hAAAA to address 5 -> next `i_memData` = 16'hAAAA with `MEM_WRITE_FIRST_EN`, 16'h0001 without.
- Out-of-range: write 16'h5555 to 16'h0100, then read 16'h0100 -> `i_memData` = 0, `o_errAddr` = 1 and stays 1; mem[0] unchanged; counters unchanged.
- Load/bus collision: in the same cycle, load 16'h00FF to addr 3 and bus-write 16'h7777 to addr 3 -> subsequent read = 16'h00FF; `o_wrCount` increments by 1.
- Saturation: issue 65 540 consecutive reads -> `o_rdCount` = 16'hFFFF. Assert `i_rst` mid-stream -> all outputs 0 immediately, while previously written array data is still readable after release.
